// File: rtl/sonar_rx_pkg.sv
// Shared types and constants for the sonar serial receiver: ASCII frame symbols,
// parser/receiver state encodings and the BCD payload layout.
package sonar_rx_pkg;

    localparam logic [7:0] DIGITO_0   = 8'h30;
    localparam logic [7:0] VIRGULA    = 8'h2C;
    localparam logic [7:0] TERMINADOR = 8'h23;

    // Codes are visible on db_estado, so they are pinned explicitly
    typedef enum logic [3:0] {
        ESPERA = 4'd0,
        ANG2   = 4'd1,
        ANG1   = 4'd2,
        ANG0   = 4'd3,
        VIRG   = 4'd4,
        DIST2  = 4'd5,
        DIST1  = 4'd6,
        DIST0  = 4'd7,
        FIM    = 4'd8
    } parser_state_e;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [3:0] centena;
        logic [3:0] dezena;
        logic [3:0] unidade;
    } bcd3_t;

    function automatic logic is_digito(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/sonar_serial_rx_if.sv
// Line input and decoded measurement outputs of the sonar receiver.
// master = line driver / consumer side, slave = the receiver itself.
interface sonar_serial_rx_if;
    logic        entrada_serial;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    modport master (output entrada_serial,
                    input  angulo, distancia, pronto, erro, db_estado);
    modport slave  (input  entrada_serial,
                    output angulo, distancia, pronto, erro, db_estado);
endinterface

// File: rtl/uart_rx_bits.sv
// UART character receiver: synchroniser, mid-bit sampling, byte and error strobes.
// SONAR_RX_PARITY_EN selects 7E1 (parity checked) instead of 8N1.
module uart_rx_bits
    import sonar_rx_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frm_err_c_o
);
    localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
    localparam int unsigned TICK_W     = $clog2(BIT_TICKS + 1);

    rx_state_e         state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q, byte_q;
    logic              byte_vld_q;
    logic              fall_c, tick_end_c, shift_en_c, stop_smp_c, char_ok_c, par_ok_c;
    logic [7:0]        data_c;

    // Line idles high, so the synchroniser and edge history reset to 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_c = prev_q & ~sync2_q;

`ifdef SONAR_RX_PARITY_EN
    assign par_ok_c = ~(^shift_q);
    assign data_c   = {1'b0, shift_q[6:0]};
`else
    assign par_ok_c = 1'b1;
    assign data_c   = shift_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= OCIOSO;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:  if (fall_c)     state_d = INICIO;
            INICIO:  if (tick_end_c) state_d = sync2_q ? OCIOSO : DADOS;
            DADOS:   if (tick_end_c && (bit_q == 3'd7)) state_d = PARADA;
            PARADA:  if (tick_end_c) state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    // Start bit is re-checked half a bit in; every later sample is one full bit apart
    always_comb begin
        tick_end_c  = (state_q == INICIO) ? (tick_q == TICK_W'(HALF_TICKS - 1))
                                          : (tick_q == TICK_W'(BIT_TICKS - 1));
        tick_d      = ((state_q == OCIOSO) || tick_end_c) ? '0 : tick_q + TICK_W'(1);
        shift_en_c  = (state_q == DADOS) && tick_end_c;
        stop_smp_c  = (state_q == PARADA) && tick_end_c;
        char_ok_c   = stop_smp_c && sync2_q && par_ok_c;
        frm_err_c_o = stop_smp_c && !(sync2_q && par_ok_c);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            byte_vld_q <= char_ok_c;
            if (state_q == OCIOSO) bit_q <= '0;
            else if (shift_en_c)   bit_q <= bit_q + 3'd1;
            if (shift_en_c) shift_q <= {sync2_q, shift_q[7:1]};
            if (char_ok_c)  byte_q  <= data_c;
        end
    end

    assign byte_o     = byte_q;
    assign byte_vld_o = byte_vld_q;

endmodule

// File: rtl/sonar_serial_rx.sv
// Sonar receiver top: UART bits plus the "AAA,DDD#" frame parser with BCD outputs.
// Character format follows SONAR_RX_PARITY_EN (see uart_rx_bits).
module sonar_serial_rx
    import sonar_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic              clock,
    input  logic              reset,
    sonar_serial_rx_if.slave  bus
);
    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;

    logic [7:0]    byte_c;
    logic          byte_vld_c, frm_err_c;
    parser_state_e state_q, state_d;
    bcd3_t         ang_sh_q, dist_sh_q, ang_q, dist_q;
    logic          pronto_q, erro_q;
    logic          dig_ok_c, err_c, commit_c;
    logic [2:0]    wr_ang_c, wr_dist_c;
    logic [3:0]    dig_c;

    uart_rx_bits #(.BIT_TICKS(BIT_TICKS)) u_bits (
        .clock       (clock),
        .reset       (reset),
        .rx_i        (bus.entrada_serial),
        .byte_o      (byte_c),
        .byte_vld_o  (byte_vld_c),
        .frm_err_c_o (frm_err_c)
    );

    assign dig_ok_c = is_digito(byte_c);
    assign dig_c    = 4'(byte_c - DIGITO_0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ESPERA;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_vld_c) begin
            case (state_q)
                ESPERA:  if (dig_ok_c) state_d = ANG1;
                ANG1:    state_d = dig_ok_c ? ANG0 : ESPERA;
                ANG0:    state_d = dig_ok_c ? VIRG : ESPERA;
                VIRG:    state_d = (byte_c == VIRGULA) ? DIST2 : ESPERA;
                DIST2:   state_d = dig_ok_c ? DIST1 : ESPERA;
                DIST1:   state_d = dig_ok_c ? DIST0 : ESPERA;
                DIST0:   state_d = dig_ok_c ? FIM : ESPERA;
                default: state_d = ESPERA;
            endcase
        end
    end

    // Shadow write enables, commit and format-error decode for the current byte
    always_comb begin
        wr_ang_c  = 3'b000;
        wr_dist_c = 3'b000;
        err_c     = 1'b0;
        commit_c  = 1'b0;
        if (byte_vld_c) begin
            case (state_q)
                ESPERA:  wr_ang_c[2]  = dig_ok_c;
                ANG1:    begin wr_ang_c[1]  = dig_ok_c; err_c = !dig_ok_c; end
                ANG0:    begin wr_ang_c[0]  = dig_ok_c; err_c = !dig_ok_c; end
                VIRG:    err_c = (byte_c != VIRGULA);
                DIST2:   begin wr_dist_c[2] = dig_ok_c; err_c = !dig_ok_c; end
                DIST1:   begin wr_dist_c[1] = dig_ok_c; err_c = !dig_ok_c; end
                DIST0:   begin wr_dist_c[0] = dig_ok_c; err_c = !dig_ok_c; end
                FIM:     begin commit_c = (byte_c == TERMINADOR); err_c = !commit_c; end
                default: err_c = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ang_sh_q  <= '0;
            dist_sh_q <= '0;
            ang_q     <= '0;
            dist_q    <= '0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            if (wr_ang_c[2])  ang_sh_q.centena  <= dig_c;
            if (wr_ang_c[1])  ang_sh_q.dezena   <= dig_c;
            if (wr_ang_c[0])  ang_sh_q.unidade  <= dig_c;
            if (wr_dist_c[2]) dist_sh_q.centena <= dig_c;
            if (wr_dist_c[1]) dist_sh_q.dezena  <= dig_c;
            if (wr_dist_c[0]) dist_sh_q.unidade <= dig_c;
            if (commit_c) begin
                ang_q  <= ang_sh_q;
                dist_q <= dist_sh_q;
            end
            pronto_q <= commit_c;
            erro_q   <= err_c | frm_err_c;
        end
    end

    assign bus.angulo    = ang_q;
    assign bus.distancia = dist_q;
    assign bus.pronto    = pronto_q;
    assign bus.erro      = erro_q;
    assign bus.db_estado = state_q;

endmodule

// File: tb/tb_sonar_serial_rx.sv
// Bench for sonar_serial_rx: serialises ASCII frames, scoreboards committed values.
// Runs a reduced baud ratio (16 clocks per bit) to keep simulation short.
module tb_sonar_serial_rx;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BT       = CLK_FREQ / BAUD;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sonar_serial_rx_if bus ();

    sonar_serial_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int n_pronto = 0;
    int n_erro   = 0;
    logic [23:0] exp_q[$];
    logic prev_pronto = 1'b0;
    logic prev_erro   = 1'b0;

    // Scoreboard: every pronto must match the oldest expected frame and last one cycle
    always @(negedge clock) begin
        logic [23:0] e;
        if (reset && bus.pronto) begin
            n_pronto++;
            n_tests++;
            if (prev_pronto) begin
                n_fail++;
                $display("FAIL pronto_width: high %0d cycles in a row, want 1", 2);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pronto_unexpected: got %h/%h, want no pronto", bus.angulo, bus.distancia);
            end else begin
                e = exp_q.pop_front();
                if (bus.angulo !== e[23:12] || bus.distancia !== e[11:0]) begin
                    n_fail++;
                    $display("FAIL frame_value: got %h/%h want %h/%h",
                             bus.angulo, bus.distancia, e[23:12], e[11:0]);
                end
            end
        end
        if (reset && bus.erro) begin
            n_erro++;
            n_tests++;
            if (prev_erro) begin
                n_fail++;
                $display("FAIL erro_width: high 2 cycles in a row, want 1");
            end
        end
        prev_pronto = reset && bus.pronto;
        prev_erro   = reset && bus.erro;
    end

    task automatic drive_bit(input logic b, input int unsigned n);
        bus.entrada_serial = b;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] c, input logic stop_v);
        drive_bit(1'b0, BT);
`ifdef SONAR_RX_PARITY_EN
        for (int i = 0; i < 7; i++) drive_bit(c[i], BT);
        drive_bit(^c[6:0], BT);
`else
        for (int i = 0; i < 8; i++) drive_bit(c[i], BT);
`endif
        drive_bit(stop_v, BT);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive_bit(1'b1, 4);
        n_tests++; if (bus.angulo !== 12'h000) begin n_fail++; $display("FAIL reset_angulo: got %h want 000", bus.angulo); end
        n_tests++; if (bus.distancia !== 12'h000) begin n_fail++; $display("FAIL reset_distancia: got %h want 000", bus.distancia); end
        n_tests++; if (bus.pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b want 0", bus.pronto); end
        n_tests++; if (bus.erro !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %b want 0", bus.erro); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", bus.db_estado); end
        reset = 1'b1;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_valid_frame;
        int p0 = n_pronto, e0 = n_erro;
        exp_q.push_back({12'h090, 12'h123});
        send_str("090,123#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_pronto - p0 != 1) begin n_fail++; $display("FAIL valid_pronto_count: got %0d want 1", n_pronto - p0); end
        n_tests++; if (n_erro - e0 != 0) begin n_fail++; $display("FAIL valid_erro_count: got %0d want 0", n_erro - e0); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL valid_estado: got %0d want 0", bus.db_estado); end
    endtask

    task automatic test_format_error;
        int p0 = n_pronto, e0 = n_erro;
        send_str("045,0");
        drive_bit(1'b1, 4);
        n_tests++; if (bus.db_estado !== 4'd6) begin n_fail++; $display("FAIL fmt_estado_dist1: got %0d want 6", bus.db_estado); end
        send_str("A");
        drive_bit(1'b1, 4);
        n_tests++; if (n_erro - e0 != 1) begin n_fail++; $display("FAIL fmt_erro_at_A: got %0d want 1", n_erro - e0); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL fmt_estado_after_A: got %0d want 0", bus.db_estado); end
        // '2' restarts a frame from ESPERA, so the trailing '#' is itself a format error
        send_str("2#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_erro - e0 != 2) begin n_fail++; $display("FAIL fmt_erro_total: got %0d want 2", n_erro - e0); end
        n_tests++; if (n_pronto - p0 != 0) begin n_fail++; $display("FAIL fmt_pronto: got %0d want 0", n_pronto - p0); end
        n_tests++; if (bus.angulo !== 12'h090 || bus.distancia !== 12'h123) begin
            n_fail++; $display("FAIL fmt_hold: got %h/%h want 090/123", bus.angulo, bus.distancia); end
        exp_q.push_back({12'h120, 12'h300});
        send_str("120,300#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_pronto - p0 != 1) begin n_fail++; $display("FAIL fmt_recover_pronto: got %0d want 1", n_pronto - p0); end
    endtask

    task automatic test_glitch;
        int p0 = n_pronto, e0 = n_erro;
        drive_bit(1'b0, BT / 4);
        drive_bit(1'b1, 3 * BT);
        n_tests++; if (n_erro - e0 != 0) begin n_fail++; $display("FAIL glitch_erro: got %0d want 0", n_erro - e0); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL glitch_estado: got %0d want 0", bus.db_estado); end
        exp_q.push_back({12'h007, 12'h999});
        send_str("007,999#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_pronto - p0 != 1) begin n_fail++; $display("FAIL glitch_next_pronto: got %0d want 1", n_pronto - p0); end
    endtask

    task automatic test_stop_error;
        int p0 = n_pronto, e0 = n_erro;
        send_byte(8'h31, 1'b0);
        drive_bit(1'b1, 2 * BT);
        n_tests++; if (n_erro - e0 != 1) begin n_fail++; $display("FAIL stop_erro: got %0d want 1", n_erro - e0); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL stop_discard: estado %0d want 0", bus.db_estado); end
`ifdef SONAR_RX_PARITY_EN
        drive_bit(1'b0, BT);
        for (int i = 0; i < 7; i++) drive_bit(i == 0 || i == 4 || i == 5, BT);
        drive_bit(1'b0, BT);
        drive_bit(1'b1, 3 * BT);
        n_tests++; if (n_erro - e0 != 2) begin n_fail++; $display("FAIL parity_erro: got %0d want 2", n_erro - e0); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL parity_discard: estado %0d want 0", bus.db_estado); end
        e0 = n_erro - 1;
`endif
        drive_bit(1'b0, 40 * BT);
        n_tests++; if (n_erro - e0 != 2) begin n_fail++; $display("FAIL low_line_erro: got %0d new pulses want 1", n_erro - e0 - 1); end
        drive_bit(1'b1, 2 * BT);
        n_tests++; if (n_erro - e0 != 2) begin n_fail++; $display("FAIL low_line_release: got %0d new pulses want 1", n_erro - e0 - 1); end
        n_tests++; if (n_pronto - p0 != 0) begin n_fail++; $display("FAIL stop_pronto: got %0d want 0", n_pronto - p0); end
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        send_str("09");
        drive_bit(1'b1, 4);
        n_tests++; if (bus.db_estado !== 4'd3) begin n_fail++; $display("FAIL mid_estado: got %0d want 3", bus.db_estado); end
        reset = 1'b0;
        drive_bit(1'b1, 3);
        n_tests++; if (bus.angulo !== 12'h000 || bus.distancia !== 12'h000) begin
            n_fail++; $display("FAIL mid_reset_out: got %h/%h want 000/000", bus.angulo, bus.distancia); end
        n_tests++; if (bus.db_estado !== 4'd0) begin n_fail++; $display("FAIL mid_reset_estado: got %0d want 0", bus.db_estado); end
        reset = 1'b1;
        drive_bit(1'b1, 4);
        p0 = n_pronto;
        exp_q.push_back({12'h180, 12'h050});
        send_str("180,050#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_pronto - p0 != 1) begin n_fail++; $display("FAIL mid_after_pronto: got %0d want 1", n_pronto - p0); end
        n_tests++; if (bus.angulo !== 12'h180 || bus.distancia !== 12'h050) begin
            n_fail++; $display("FAIL mid_after_value: got %h/%h want 180/050", bus.angulo, bus.distancia); end
    endtask

    task automatic test_back_to_back;
        int p0 = n_pronto, e0 = n_erro;
        exp_q.push_back({12'h359, 12'h001});
        exp_q.push_back({12'h000, 12'h000});
        exp_q.push_back({12'h999, 12'h999});
        send_str("359,001#");
        send_str("000,000#");
        send_str("999,999#");
        drive_bit(1'b1, 4);
        n_tests++; if (n_pronto - p0 != 3) begin n_fail++; $display("FAIL b2b_pronto: got %0d want 3", n_pronto - p0); end
        n_tests++; if (n_erro - e0 != 0) begin n_fail++; $display("FAIL b2b_erro: got %0d want 0", n_erro - e0); end
    endtask

    initial begin
        bus.entrada_serial = 1'b1;
        @(negedge clock);
        test_reset();
        test_valid_frame();
        test_format_error();
        test_glitch();
        test_stop_error();
        test_reset_mid_frame();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pronto: %0d frames never committed, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sonar_serial_rx.md
# sonar_serial_rx

Receiver-side stage that consumes the sonar's serial output and recovers the measurement. It deserialises the UART line, then parses the fixed 8-character ASCII frame `AAA,DDD#` (angle, comma, distance, terminator). It presents angle and distance as 3-digit BCD words with a one-cycle valid strobe, so a second board or display block can reuse the sonar data without software.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. BIT_TICKS = CLK_FREQ/BAUD, integer-truncated.

Ports:
- clock, in, 1: single system clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-low. Clears every register immediately.
- entrada_serial, in, 1: UART line. Idle high. Asynchronous to clock.
- angulo, out, 12: BCD angle `{centena,dezena,unidade}`. Reset 0x000.
- distancia, out, 12: BCD distance, same layout. Reset 0x000.
- pronto, out, 1: one-cycle pulse when angulo/distancia are updated. Reset 0.
- erro, out, 1: one-cycle pulse on a framing, parity or format error. Reset 0.
- db_estado, out, 4: parser state code. Reset 0 (ESPERA).

## Operation
- Line input passes through a 2-flop synchroniser before any use. The synchronised value resets to 1.
- Bit receiver, states OCIOSO, INICIO, DADOS, PARADA:
  - OCIOSO → INICIO on a synchronised 1→0.
  - INICIO waits BIT_TICKS/2 cycles and resamples. If the sample is 1, the event is a glitch: return to OCIOSO with no byte and no error. If 0, go to DADOS.
  - DADOS samples each bit after BIT_TICKS cycles, LSB first.
  - PARADA samples the stop bit. Stop = 1 produces a one-cycle byte strobe with the byte. Stop = 0 is discarded and pulses erro.
  - After PARADA the receiver returns to OCIOSO and rearms on the next falling edge.
- Parser, states ESPERA(0), ANG2(1), ANG1(2), ANG0(3), VIRG(4), DIST2(5), DIST1(6), DIST0(7), FIM(8):
  - ESPERA: an ASCII digit '0'–'9' stores the angle hundreds digit and moves to ANG1. Any other byte is ignored silently.
  - Digit states store `byte-0x30` into the matching nibble of a shadow register.
  - VIRG requires ',' (0x2C). FIM requires '#' (0x23).
  - A wrong character in any state other than ESPERA pulses erro, returns to ESPERA and leaves the shadow values uncommitted.
  - FIM with '#' copies the shadow registers to angulo/distancia, pulses pronto and returns to ESPERA.
- angulo/distancia hold their last committed values indefinitely. They never show partial frames.
- No range checks on values, e.g. 999 is accepted.

## Timing
- Bit sample points: start + BIT_TICKS/2 + k·BIT_TICKS, with k = 1..N for the data/parity bits and the stop bit.
- The byte strobe is asserted the cycle after the stop sample. The parser consumes it in that same cycle.
- pronto and the new output values appear together, exactly 1 clock after the '#' byte strobe. pronto stays high for 1 cycle.
- erro is asserted 1 clock after the offending strobe, or after the stop/parity sample. It stays high for 1 cycle.
- Back-to-back frames with zero idle between stop and start are received without loss. The parser is always ready in the strobe cycle.
- A reset mid-byte or mid-frame aborts the byte or frame. Outputs return to reset values. A new frame is accepted starting from the next start bit.
- Line held low continuously: one erro pulse from the bad stop bit. No further bytes until the line returns high.

## Configuration
- SONAR_RX_PARITY_EN defined:
  - Character format is 7 data bits + even parity + 1 stop.
  - A parity mismatch discards the byte and pulses erro, with the same timing as a framing error.
  - The parser compares 7-bit ASCII.
- SONAR_RX_PARITY_EN undefined: character format is 8N1 with no parity logic. The parser compares all 8 bits.

## Structure
- Package sonar_rx_pkg holds:
  - ASCII constants: DIGITO_0 = 0x30, VIRGULA = 0x2C, TERMINADOR = 0x23.
  - The parser state enum with the codes listed above, which are driven on db_estado.
  - The receiver state enum.
- One sub-module, uart_rx_bits: synchroniser, tick counter, bit counter and shift register. It outputs the byte, the byte strobe and the frame-error strobe.
- The parser FSM and output registers live in sonar_serial_rx.

## Test plan
- Send "090,123#" at BAUD → angulo = 0x090, distancia = 0x123. pronto pulses once, 1 clock after the '#' strobe. erro stays 0.
- Send "045,0A2#" → one erro pulse at 'A'. Outputs keep their previous values. A following "120,300#" → 0x120/0x300.
- Low glitch of BIT_TICKS/4 cycles on an idle line → no byte strobe, no erro. The next valid frame is decoded correctly.
- Byte with its stop bit forced 0 → erro pulse, no pronto. With SONAR_RX_PARITY_EN defined, a byte with flipped parity → erro pulse.
- Assert reset after "09" of a frame, release it, then send "180,050#" → outputs 0x000 during reset, then 0x180/0x050 with a single pronto.
- Three frames back-to-back with no idle gap → three pronto pulses with the correct values each time.
